// File: rtl/du_tx_arbiter_if.sv
// Tx FIFO write-port sharing bus between the byte producers and du_tx_arbiter.
// master: producer/FIFO side driving requests, data and full flag.
// slave : arbiter side returning grant, FIFO write strobe/data and status.
interface du_tx_arbiter_if #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned NB_UART_DATA = 8
);
  logic [N_REQ-1:0]              i_req;
  logic [N_REQ-1:0]              i_last;
  logic [N_REQ*NB_UART_DATA-1:0] i_wdata;
  logic                          i_tx_full;
  logic [N_REQ-1:0]              o_gnt;
  logic                          o_wr;
  logic [NB_UART_DATA-1:0]       o_wdata;
  logic                          o_tx_start;
  logic                          o_busy;
  logic                          o_timeout;

  modport master (
    output i_req, i_last, i_wdata, i_tx_full,
    input  o_gnt, o_wr, o_wdata, o_tx_start, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_last, i_wdata, i_tx_full,
    output o_gnt, o_wr, o_wdata, o_tx_start, o_busy, o_timeout
  );
endinterface

// File: rtl/du_tx_arbiter.sv
// du_tx_arbiter: round-robin, frame-atomic sharing of the debug-unit UART Tx
// FIFO write port between N_REQ byte producers.
// Optional stall watchdog enabled by defining DU_TXARB_TIMEOUT_EN; without it
// o_timeout stays 0 and a stalled owner keeps the port indefinitely.
module du_tx_arbiter #(
  parameter int unsigned NB_UART_DATA   = 8,
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned NB_TIMEOUT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              i_rst,
  du_tx_arbiter_if.slave    bus
);

  localparam int unsigned NB_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  logic [NB_IDX-1:0]  owner;
  logic [NB_IDX-1:0]  last_winner;
  logic [NB_IDX-1:0]  pick;
  logic [N_REQ-1:0]   gnt_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               timeout_q;
  logic               accept;
  logic               frame_end;
  logic               stall_exp;

  // Round-robin pick: first asserted request after last_winner, wrapping.
  always_comb begin
    int idx;
    idx  = 0;
    pick = last_winner;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      idx = int'(last_winner) + i;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (bus.i_req[NB_IDX'(idx)]) pick = NB_IDX'(idx);
    end
  end

  // A byte is taken only from the lock owner and only when the FIFO has room.
  always_comb begin
    accept    = (state == LOCKED) & bus.i_req[owner] & ~bus.i_tx_full;
    frame_end = accept & bus.i_last[owner];
  end

  // FIFO write port follows the owner's byte in the same cycle; data zeroed when idle.
  always_comb begin
    bus.o_wr    = accept;
    bus.o_wdata = accept ? bus.i_wdata[int'(owner)*int'(NB_UART_DATA) +: NB_UART_DATA]
                         : '0;
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;

`ifdef DU_TXARB_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] stall_cnt;
  logic [NB_TIMEOUT-1:0] stall_cnt_nxt;

  // Saturating increment; expiry when the count reaches TIMEOUT_CYCLES-1.
  always_comb begin
    stall_cnt_nxt = (&stall_cnt) ? stall_cnt : stall_cnt + NB_TIMEOUT'(1);
    stall_exp     = (state == LOCKED) & ~accept &
                    (stall_cnt_nxt == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));
  end

  // Counts locked cycles without an accepted byte; held at 0 outside LOCKED.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if ((state != LOCKED) || accept) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
    end
  end
`else
  logic unused_cfg;
  assign stall_exp  = 1'b0;
  assign unused_cfg = ^{32'(NB_TIMEOUT), 32'(TIMEOUT_CYCLES)};
`endif

  // Frame lock FSM with registered grant, busy and completion pulses.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_winner <= NB_IDX'(N_REQ - 1);
      gnt_q       <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.i_req) begin
            owner  <= pick;
            gnt_q  <= N_REQ'(1) << pick;
            busy_q <= 1'b1;
            state  <= LOCKED;
          end
        end
        LOCKED: begin
          if (frame_end || stall_exp) begin
            gnt_q      <= '0;
            tx_start_q <= 1'b1;
            timeout_q  <= stall_exp;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          last_winner <= owner;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_du_tx_arbiter.sv
// Directed self-checking bench for du_tx_arbiter (N_REQ=4, 8-bit bytes).
module tb_du_tx_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned NB    = 8;

  logic clk = 1'b0;
  logic i_rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  du_tx_arbiter_if #(.N_REQ(N_REQ), .NB_UART_DATA(NB)) bus ();

  du_tx_arbiter #(
    .NB_UART_DATA  (NB),
    .N_REQ         (N_REQ),
    .NB_TIMEOUT    (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic [3:0] req, input logic [3:0] last,
                       input logic [31:0] wdata, input logic full);
    @(negedge clk);
    bus.i_req     = req;
    bus.i_last    = last;
    bus.i_wdata   = wdata;
    bus.i_tx_full = full;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_rst         = 1'b1;
    bus.i_req     = '0;
    bus.i_last    = '0;
    bus.i_wdata   = '0;
    bus.i_tx_full = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_rst         = 1'b1;
    bus.i_req     = 4'b1111;
    bus.i_last    = 4'b1111;
    bus.i_wdata   = 32'hFFFF_FFFF;
    bus.i_tx_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", bus.o_gnt); end
    n_cmp++; if (bus.o_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", bus.o_wr); end
    n_cmp++; if (bus.o_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata: got %h want 00", bus.o_wdata); end
    n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b want 0", bus.o_tx_start); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", bus.o_timeout); end
    i_rst = 1'b0;
  endtask

  task automatic test_single_byte();
    apply_reset();
    drive(4'b0100, 4'b0100, 32'h0005_0000, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL sb_gnt_t0: got %b want 0000", bus.o_gnt); end
    drive(4'b0100, 4'b0100, 32'h0005_0000, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0100) begin n_err++; $display("FAIL sb_gnt_t1: got %b want 0100", bus.o_gnt); end
    n_cmp++; if (bus.o_wr !== 1'b1) begin n_err++; $display("FAIL sb_wr_t1: got %b want 1", bus.o_wr); end
    n_cmp++; if (bus.o_wdata !== 8'h05) begin n_err++; $display("FAIL sb_wdata_t1: got %h want 05", bus.o_wdata); end
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_t1: got %b want 1", bus.o_busy); end
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_err++; $display("FAIL sb_tx_start_t2: got %b want 1", bus.o_tx_start); end
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL sb_gnt_t2: got %b want 0000", bus.o_gnt); end
    n_cmp++; if (bus.o_wr !== 1'b0) begin n_err++; $display("FAIL sb_wr_t2: got %b want 0", bus.o_wr); end
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_err++; $display("FAIL sb_tx_start_t3: got %b want 0", bus.o_tx_start); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL sb_busy_t3: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_round_robin();
    logic       exp_wr;
    logic       exp_ts;
    int         k;
    logic [3:0] exp_gnt;
    logic [7:0] exp_data;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      drive(4'b1111, 4'b1111, 32'h1312_1110, 1'b0);
      exp_wr   = (c >= 1) && (((c - 1) % 3) == 0);
      exp_ts   = (c >= 2) && (((c - 2) % 3) == 0);
      k        = (c >= 1) ? ((c - 1) / 3) % 4 : 0;
      exp_gnt  = exp_wr ? (4'b0001 << k) : 4'b0000;
      exp_data = exp_wr ? 8'(8'h10 + k) : 8'h00;
      n_cmp++; if (bus.o_wr !== exp_wr) begin n_err++; $display("FAIL rr_wr c%0d: got %b want %b", c, bus.o_wr, exp_wr); end
      n_cmp++; if (bus.o_gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", c, bus.o_gnt, exp_gnt); end
      n_cmp++; if (bus.o_wdata !== exp_data) begin n_err++; $display("FAIL rr_wdata c%0d: got %h want %h", c, bus.o_wdata, exp_data); end
      n_cmp++; if (bus.o_tx_start !== exp_ts) begin n_err++; $display("FAIL rr_tx_start c%0d: got %b want %b", c, bus.o_tx_start, exp_ts); end
    end
  endtask

  task automatic test_no_interleave();
    logic [7:0] bytes [4];
    bytes[0] = 8'h01; bytes[1] = 8'hAA; bytes[2] = 8'hBB; bytes[3] = 8'h04;
    apply_reset();
    drive(4'b0010, 4'b0001, {16'h0, 8'h01, 8'h77}, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL ni_gnt_c0: got %b want 0000", bus.o_gnt); end
    for (int b = 0; b < 4; b++) begin
      drive(4'b0011, (b == 3) ? 4'b0011 : 4'b0001, {16'h0, bytes[b], 8'h77}, 1'b0);
      n_cmp++; if (bus.o_gnt !== 4'b0010) begin n_err++; $display("FAIL ni_gnt b%0d: got %b want 0010", b, bus.o_gnt); end
      n_cmp++; if (bus.o_wr !== 1'b1) begin n_err++; $display("FAIL ni_wr b%0d: got %b want 1", b, bus.o_wr); end
      n_cmp++; if (bus.o_wdata !== bytes[b]) begin n_err++; $display("FAIL ni_wdata b%0d: got %h want %h", b, bus.o_wdata, bytes[b]); end
    end
    drive(4'b0001, 4'b0001, {16'h0, 8'h00, 8'h77}, 1'b0);
    n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_err++; $display("FAIL ni_tx_start_rel: got %b want 1", bus.o_tx_start); end
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL ni_gnt_rel: got %b want 0000", bus.o_gnt); end
    drive(4'b0001, 4'b0001, {16'h0, 8'h00, 8'h77}, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL ni_gnt_idle: got %b want 0000", bus.o_gnt); end
    n_cmp++; if (bus.o_wr !== 1'b0) begin n_err++; $display("FAIL ni_wr_idle: got %b want 0", bus.o_wr); end
    drive(4'b0001, 4'b0001, {16'h0, 8'h00, 8'h77}, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0001) begin n_err++; $display("FAIL ni_gnt_req0: got %b want 0001", bus.o_gnt); end
    n_cmp++; if (bus.o_wdata !== 8'h77) begin n_err++; $display("FAIL ni_wdata_req0: got %h want 77", bus.o_wdata); end
  endtask

  task automatic test_backpressure();
    int n_ts;
    n_ts = 0;
    apply_reset();
    drive(4'b0100, 4'b0000, 32'h0003_0000, 1'b0);
    drive(4'b0100, 4'b0000, 32'h0003_0000, 1'b0);
    n_cmp++; if (bus.o_wdata !== 8'h03) begin n_err++; $display("FAIL bp_wdata_first: got %h want 03", bus.o_wdata); end
    if (bus.o_tx_start === 1'b1) n_ts++;
    for (int c = 0; c < 3; c++) begin
      drive(4'b0100, 4'b0100, 32'h0004_0000, 1'b1);
      n_cmp++; if (bus.o_wr !== 1'b0) begin n_err++; $display("FAIL bp_wr_full c%0d: got %b want 0", c, bus.o_wr); end
      n_cmp++; if (bus.o_gnt !== 4'b0100) begin n_err++; $display("FAIL bp_gnt_full c%0d: got %b want 0100", c, bus.o_gnt); end
      if (bus.o_tx_start === 1'b1) n_ts++;
    end
    drive(4'b0100, 4'b0100, 32'h0004_0000, 1'b0);
    n_cmp++; if (bus.o_wr !== 1'b1) begin n_err++; $display("FAIL bp_wr_retry: got %b want 1", bus.o_wr); end
    n_cmp++; if (bus.o_wdata !== 8'h04) begin n_err++; $display("FAIL bp_wdata_retry: got %h want 04", bus.o_wdata); end
    if (bus.o_tx_start === 1'b1) n_ts++;
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_err++; $display("FAIL bp_tx_start: got %b want 1", bus.o_tx_start); end
    if (bus.o_tx_start === 1'b1) n_ts++;
    for (int c = 0; c < 2; c++) begin
      drive(4'b0000, 4'b0000, 32'h0, 1'b0);
      if (bus.o_tx_start === 1'b1) n_ts++;
    end
    n_cmp++; if (n_ts !== 1) begin n_err++; $display("FAIL bp_tx_start_count: got %0d want 1", n_ts); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    drive(4'b0010, 4'b0010, 32'h0000_2100, 1'b0);
    drive(4'b0010, 4'b0010, 32'h0000_2100, 1'b0);
    n_cmp++; if (bus.o_wdata !== 8'h21) begin n_err++; $display("FAIL rm_pre_wdata: got %h want 21", bus.o_wdata); end
    drive(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0);
    drive(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0);
    drive(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0100) begin n_err++; $display("FAIL rm_gnt_byte1: got %b want 0100", bus.o_gnt); end
    drive(4'b0100, 4'b0000, 32'h00A2_0000, 1'b0);
    n_cmp++; if (bus.o_wdata !== 8'hA2) begin n_err++; $display("FAIL rm_wdata_byte2: got %h want a2", bus.o_wdata); end
    @(negedge clk);
    i_rst = 1'b1;
    bus.i_wdata = 32'h00A3_0000;
    @(negedge clk);
    i_rst         = 1'b0;
    bus.i_req     = 4'b0111;
    bus.i_last    = 4'b0111;
    bus.i_wdata   = 32'h00C2_C1C0;
    #1;
    n_cmp++; if (bus.o_gnt !== 4'b0000) begin n_err++; $display("FAIL rm_gnt_after_rst: got %b want 0000", bus.o_gnt); end
    n_cmp++; if (bus.o_wr !== 1'b0) begin n_err++; $display("FAIL rm_wr_after_rst: got %b want 0", bus.o_wr); end
    n_cmp++; if (bus.o_wdata !== 8'h00) begin n_err++; $display("FAIL rm_wdata_after_rst: got %h want 00", bus.o_wdata); end
    n_cmp++; if (bus.o_tx_start !== 1'b0) begin n_err++; $display("FAIL rm_tx_start_after_rst: got %b want 0", bus.o_tx_start); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rm_busy_after_rst: got %b want 0", bus.o_busy); end
    drive(4'b0111, 4'b0111, 32'h00C2_C1C0, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0001) begin n_err++; $display("FAIL rm_gnt_rearb: got %b want 0001", bus.o_gnt); end
    n_cmp++; if (bus.o_wdata !== 8'hC0) begin n_err++; $display("FAIL rm_wdata_rearb: got %h want c0", bus.o_wdata); end
  endtask

  task automatic test_timeout();
    int n_to;
    n_to = 0;
    apply_reset();
    drive(4'b0010, 4'b0000, 32'h0000_3100, 1'b0);
    drive(4'b0010, 4'b0000, 32'h0000_3100, 1'b0);
    n_cmp++; if (bus.o_wr !== 1'b1) begin n_err++; $display("FAIL to_wr_first: got %b want 1", bus.o_wr); end
`ifdef DU_TXARB_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      drive(4'b0100, 4'b0100, 32'h0042_0000, 1'b0);
      n_cmp++; if (bus.o_gnt !== 4'b0010) begin n_err++; $display("FAIL to_gnt_stall c%0d: got %b want 0010", c, bus.o_gnt); end
      n_cmp++; if (bus.o_timeout !== 1'b0) begin n_err++; $display("FAIL to_timeout_early c%0d: got %b want 0", c, bus.o_timeout); end
    end
    drive(4'b0100, 4'b0100, 32'h0042_0000, 1'b0);
    n_cmp++; if (bus.o_timeout !== 1'b1) begin n_err++; $display("FAIL to_timeout_pulse: got %b want 1", bus.o_timeout); end
    n_cmp++; if (bus.o_tx_start !== 1'b1) begin n_err++; $display("FAIL to_tx_start: got %b want 1", bus.o_tx_start); end
    drive(4'b0100, 4'b0100, 32'h0042_0000, 1'b0);
    n_cmp++; if (bus.o_timeout !== 1'b0) begin n_err++; $display("FAIL to_timeout_clear: got %b want 0", bus.o_timeout); end
    drive(4'b0100, 4'b0100, 32'h0042_0000, 1'b0);
    n_cmp++; if (bus.o_gnt !== 4'b0100) begin n_err++; $display("FAIL to_gnt_next: got %b want 0100", bus.o_gnt); end
    n_cmp++; if (bus.o_wdata !== 8'h42) begin n_err++; $display("FAIL to_wdata_next: got %h want 42", bus.o_wdata); end
`else
    for (int c = 2; c < 22; c++) begin
      drive(4'b0100, 4'b0100, 32'h0042_0000, 1'b0);
      if (bus.o_timeout === 1'b1 || bus.o_tx_start === 1'b1) n_to++;
    end
    n_cmp++; if (bus.o_gnt !== 4'b0010) begin n_err++; $display("FAIL to_gnt_held: got %b want 0010", bus.o_gnt); end
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL to_busy_held: got %b want 1", bus.o_busy); end
    n_cmp++; if (n_to !== 0) begin n_err++; $display("FAIL to_no_release: got %0d pulses want 0", n_to); end
`endif
  endtask

  initial begin
    i_rst         = 1'b1;
    bus.i_req     = '0;
    bus.i_last    = '0;
    bus.i_wdata   = '0;
    bus.i_tx_full = 1'b0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_reset_mid_frame();
    test_timeout();
    apply_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
